// File: rtl/muldiv_unit_if.sv
// Core-side bundle for the RV32M multiply/divide unit: launch request with
// operands and destination, plus the busy flag and the result write strobe.
interface muldiv_unit_if #(
  parameter int DATA_LEN     = 32,
  parameter int REG_ADDR_LEN = 5
);

  logic                    i_start;
  logic [2:0]              i_funct3;
  logic [DATA_LEN-1:0]     i_rs1_data;
  logic [DATA_LEN-1:0]     i_rs2_data;
  logic [REG_ADDR_LEN-1:0] i_rd_addr;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_write_enable;
  logic [REG_ADDR_LEN-1:0] o_rd_addr;
  logic [DATA_LEN-1:0]     o_result;

  // Core pipeline side: issues operations, watches busy and the write strobe
  modport master (
    output i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
    input  o_busy, o_done, o_write_enable, o_rd_addr, o_result
  );

  // Arithmetic unit side
  modport slave (
    input  i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
    output o_busy, o_done, o_write_enable, o_rd_addr, o_result
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// launch, a 32-step shift-add (multiply) or restoring shift-subtract (divide)
// runs in a shared hi/lo register pair, and the sign is applied in a final
// fix-up cycle that also registers the result and pulses the write strobe.
// Division by zero and signed overflow skip the iteration entirely.
module muldiv_unit #(
  parameter int DATA_LEN     = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input logic           i_clk,
  input logic           i_rstn,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [DATA_LEN-1:0] MIN_NEG   = {1'b1, {(DATA_LEN-1){1'b0}}};
  localparam logic [5:0]          LAST_ITER = 6'(DATA_LEN - 1);

  state_t                  state;
  logic [5:0]              count;
  logic [2:0]              funct3_q;
  logic                    neg_q;
  logic [DATA_LEN-1:0]     hi_q;
  logic [DATA_LEN-1:0]     lo_q;
  logic [DATA_LEN-1:0]     mag_b_q;
  logic                    busy_q;
  logic                    done_q;
  logic [REG_ADDR_LEN-1:0] rd_q;
  logic [DATA_LEN-1:0]     result_q;

  logic                    is_div;
  logic                    a_signed;
  logic                    b_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_LEN-1:0]     mag_a;
  logic [DATA_LEN-1:0]     mag_b;
  logic                    start_neg;
  logic                    div_zero;
  logic                    div_ovf;

  logic [DATA_LEN:0]       mul_sum;
  logic [DATA_LEN:0]       div_shift;
  logic                    div_fits;
  logic [DATA_LEN-1:0]     div_sub;
  logic [2*DATA_LEN-1:0]   product_fix;
  logic [DATA_LEN-1:0]     fix_result;

  // Decode the incoming op: per-operand signedness, magnitudes, result sign
  // and the two cases that bypass the iteration
  always_comb begin
    is_div    = bus.i_funct3[2];
    a_signed  = is_div ? ~bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
    b_signed  = is_div ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
    a_neg     = a_signed & bus.i_rs1_data[DATA_LEN-1];
    b_neg     = b_signed & bus.i_rs2_data[DATA_LEN-1];
    mag_a     = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
    mag_b     = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
    start_neg = (is_div & bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div & (bus.i_rs2_data == '0);
    div_ovf   = is_div & ~bus.i_funct3[0] & (bus.i_rs1_data == MIN_NEG)
                & (bus.i_rs2_data == '1);
  end

  // One iteration step of each algorithm, plus sign fix-up and result select
  always_comb begin
    mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_b_q : '0)};
    div_shift   = {hi_q, lo_q[DATA_LEN-1]};
    div_fits    = (div_shift >= {1'b0, mag_b_q});
    div_sub     = div_shift[DATA_LEN-1:0] - mag_b_q;
    product_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (funct3_q)
      3'b000:                 fix_result = product_fix[DATA_LEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = product_fix[2*DATA_LEN-1:DATA_LEN];
      3'b100, 3'b101:         fix_result = neg_q ? -lo_q : lo_q;
      default:                fix_result = neg_q ? -hi_q : hi_q;
    endcase
  end

  // Control FSM and datapath registers; special cases preload the quotient
  // (lo) and remainder (hi) slots with the architectural answer and no sign
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= IDLE;
      count    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            funct3_q <= bus.i_funct3;
            rd_q     <= bus.i_rd_addr;
            busy_q   <= 1'b1;
            count    <= '0;
            if (div_zero) begin
              hi_q  <= bus.i_rs1_data;
              lo_q  <= '1;
              neg_q <= 1'b0;
              state <= FIX;
            end else if (div_ovf) begin
              hi_q  <= '0;
              lo_q  <= MIN_NEG;
              neg_q <= 1'b0;
              state <= FIX;
            end else begin
              hi_q    <= '0;
              lo_q    <= mag_a;
              mag_b_q <= mag_b;
              neg_q   <= start_neg;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          count <= count + 6'd1;
          if (funct3_q[2]) begin
            hi_q <= div_fits ? div_sub : div_shift[DATA_LEN-1:0];
            lo_q <= {lo_q[DATA_LEN-2:0], div_fits};
          end else begin
            hi_q <= mul_sum[DATA_LEN:1];
            lo_q <= {mul_sum[0], lo_q[DATA_LEN-1:1]};
          end
          if (count == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_result;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_write_enable = done_q;
  assign bus.o_rd_addr      = rd_q;
  assign bus.o_result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: each launch pushes the
// architecturally expected result, destination and arrival cycle; a monitor
// pops and compares whenever the unit strobes a result.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          due_cycle;
    int          busy_len;
  } exp_t;

  logic i_clk;
  logic i_rstn;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  int   busy_run;
  logic prev_done;
  exp_t sb_q[$];

  muldiv_unit_if #(.DATA_LEN(32), .REG_ADDR_LEN(5)) bus();

  muldiv_unit #(.DATA_LEN(32), .REG_ADDR_LEN(5)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Edge counter used to timestamp launches and results
  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Safety net against a hung run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics from plain arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      ps;
    logic [63:0] p;
    sa = a;
    sb = b;
    ref_model = '0;
    case (f)
      3'd0: begin ps = longint'(sa) * longint'(sb); p = ps; ref_model = p[31:0]; end
      3'd1: begin ps = longint'(sa) * longint'(sb); p = ps; ref_model = p[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'd0, b}); p = ps; ref_model = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; ref_model = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'h8000_0000;
        else ref_model = sa / sb;
      end
      3'd5: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'd0;
        else ref_model = sa % sb;
      end
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation as soon as the unit is free and log its expectation
  task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int   waited;
    int   lat;
    exp_t e;
    waited = 0;
    @(negedge i_clk);
    while (bus.o_busy && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    if (waited >= 200) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL busy_timeout: got busy for %0d cycles expected at most 200", waited);
    end
    lat         = is_special(f, a, b) ? 2 : 34;
    e.result    = ref_model(f, a, b);
    e.rd        = rd;
    e.due_cycle = cyc + lat;
    e.busy_len  = lat - 1;
    sb_q.push_back(e);
    bus.i_start    = 1'b1;
    bus.i_funct3   = f;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_rd_addr  = rd;
    @(negedge i_clk);
    bus.i_start    = 1'b0;
    bus.i_funct3   = 3'($urandom);
    bus.i_rs1_data = $urandom;
    bus.i_rs2_data = $urandom;
    bus.i_rd_addr  = 5'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    check_output({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
    check_output({tag, "_we"}, {31'd0, bus.o_write_enable}, 32'd0);
    check_output({tag, "_rd"}, {27'd0, bus.o_rd_addr}, 32'd0);
    check_output({tag, "_result"}, bus.o_result, 32'd0);
  endtask

  // Monitor: pop the oldest expectation whenever a result is strobed
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rstn) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.o_done || bus.o_write_enable)
        check_output("we_equals_done", {31'd0, bus.o_write_enable}, {31'd0, bus.o_done});
      if (bus.o_done) begin
        if (prev_done) check_output("done_width", 32'd1, 32'd0);
        if (sb_q.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_output("result", bus.o_result, e.result);
          check_output("rd_addr", {27'd0, bus.o_rd_addr}, {27'd0, e.rd});
          check_output("done_cycle", 32'(cyc), 32'(e.due_cycle));
          check_output("busy_cycles", 32'(busy_run), 32'(e.busy_len));
          check_output("busy_in_done", {31'd0, bus.o_busy}, 32'd0);
        end
        busy_run = 0;
      end else if (bus.o_busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
      prev_done = bus.o_done;
    end
  end

  // Main sequence: reset, directed corners, ignored start, abort, random ops
  initial begin
    int waited;
    tests_run      = 0;
    tests_failed   = 0;
    i_rstn         = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_funct3   = '0;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_rd_addr  = '0;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_rstn = 1'b1;

    apply_stimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    apply_stimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    apply_stimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    apply_stimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    apply_stimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    apply_stimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    apply_stimulus(3'd5, 32'd100, 32'd7, 5'd6);
    apply_stimulus(3'd7, 32'd100, 32'd7, 5'd7);
    apply_stimulus(3'd5, 32'd55, 32'd0, 5'd8);
    apply_stimulus(3'd6, 32'h0000_1234, 32'd0, 5'd10);
    apply_stimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    apply_stimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

    // A start issued mid-calculation must not disturb the running op
    apply_stimulus(3'd0, 32'd1234, 32'd5678, 5'd12);
    repeat (10) @(negedge i_clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = 3'd5;
    bus.i_rs1_data = 32'd999;
    bus.i_rs2_data = 32'd3;
    bus.i_rd_addr  = 5'd13;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    apply_stimulus(3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd14);

    // Abort a divide with reset at its tenth edge
    apply_stimulus(3'd4, 32'd5000, 32'd7, 5'd15);
    repeat (9) @(negedge i_clk);
    i_rstn = 1'b0;
    @(negedge i_clk);
    check_idle_outputs("abort");
    sb_q.delete();
    i_rstn = 1'b1;
    repeat (40) @(negedge i_clk);
    check_idle_outputs("after_abort");
    apply_stimulus(3'd0, 32'd3, 32'd5, 5'd16);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge i_clk);
      apply_stimulus(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom));
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    if (sb_q.size() != 0) check_output("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
